// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory interface stage.
package lc3_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } mem_state_e;

  localparam word_t WORD_ZERO = 16'h0000;

endpackage

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface stage: MAR/MDR registers and the memory request handshake.
// MDR feeds the gateMDR tristate; control holds mio_en until ready is seen.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [WORD_W-1:0] mar_out,
  output logic [WORD_W-1:0] mdr_out,
  output logic              ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [WORD_W-1:0] Zero = WORD_W'(WORD_ZERO);

  mem_state_e        state_q, state_d;
  logic              dir_q, dir_d;  // 1 = write
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      mar_q   <= Zero;
      mdr_q   <= Zero;
      rbuf_q  <= Zero;
      addr_q  <= Zero;
      wdata_q <= Zero;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rbuf_q  <= rbuf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rbuf_d  = rbuf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      StIdle: begin
        if (mio_en) begin
          // Latch from the pre-edge MAR/MDR so a same-edge ld_mar cannot leak in.
          state_d = StReq;
          addr_d  = mar_q;
          wdata_d = mdr_q;
          dir_d   = r_w;
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          if (!dir_q) rbuf_d = mem_rdata;
        end
      end
      StDone: begin
        if (!mio_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ld_mar) mar_d = bus_in;

    // mio_en selects the MDR source: bus when low, completed read data when high.
    if (ld_mdr) begin
      if (!mio_en) begin
        mdr_d = bus_in;
      end else if (state_q == StDone && !dir_q) begin
        mdr_d = rbuf_q;
      end
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ready     = (state_q == StDone);
  assign mem_re    = (state_q == StReq) && !dir_q;
  assign mem_we    = (state_q == StReq) && dir_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Self-checking bench for lc3_mem_if: directed and random accesses against a memory model.
module tb_lc3_mem_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata, mem_rdata;
  logic        ready, mem_re, mem_we, mem_ack;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_mar, exp_mdr;

  always #5 clk = ~clk;

  lc3_mem_if #(.WORD_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_in   (bus_in),
    .ld_mar   (ld_mar),
    .ld_mdr   (ld_mdr),
    .mio_en   (mio_en),
    .r_w      (r_w),
    .mar_out  (mar_out),
    .mdr_out  (mdr_out),
    .ready    (ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
    exp_mar = v;
    chk("mar_load", mar_out, exp_mar);
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
    exp_mdr = v;
    chk("mdr_load", mdr_out, exp_mdr);
  endtask

  // One full access: request, waitn cycles without ack, DONE held for hold extra cycles.
  task automatic access(input logic wr, input int waitn, input logic mid_mar, input int hold);
    logic [15:0] a, d;
    int n, strobes;
    bit done;
    a = exp_mar; d = exp_mdr;
    n = 0; strobes = 0; done = 0;
    r_w = wr; mio_en = 1'b1; mem_ack = 1'b0;
    tick();
    for (int k = 0; k < 40 && !done; k++) begin
      if (wr ? mem_we : mem_re) strobes++;
      chk("req_addr", mem_addr, a);
      chk("wrong_strobe", wr ? mem_re : mem_we, 0);
      chk("ready_in_req", ready, 0);
      mem_ack = (n == waitn);
      mem_rdata = mem_ack ? rd(a) : 16'($urandom);
      if (mid_mar && n == 0) begin
        bus_in = 16'h0042; ld_mar = 1'b1; exp_mar = 16'h0042;
      end
      tick();
      ld_mar = 1'b0; mem_ack = 1'b0; n++;
      if (ready) done = 1;
    end
    chk("ready_timeout", done, 1);
    chk("latency_edges", n + 1, waitn + 2);
    chk("strobe_cycles", strobes, waitn + 1);
    chk("mar_after", mar_out, exp_mar);
    if (wr) begin
      chk("wdata", mem_wdata, d);
      mem[a] = d;
    end
    // ld_mdr in DONE: loads read data after a read, no effect after a write
    bus_in = 16'($urandom); ld_mdr = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'($urandom);
    tick();
    ld_mdr = 1'b0; mem_ack = 1'b0;
    if (!wr) exp_mdr = rd(a);
    chk("mdr_done", mdr_out, exp_mdr);
    for (int h = 0; h < hold; h++) begin
      chk("held_ready", ready, 1);
      chk("held_strobes", {mem_re, mem_we}, 0);
      tick();
    end
    chk("ready_before_drop", ready, 1);
    mio_en = 1'b0;
    tick();
    chk("ready_after_drop", ready, 0);
    chk("idle_strobes", {mem_re, mem_we}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      bus_in = 16'($urandom); ld_mar = 1'($urandom); ld_mdr = 1'($urandom);
      mio_en = 1'($urandom); r_w = 1'($urandom); mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      tick();
    end
    chk("rst_outputs", {mar_out, mdr_out}, 0);
    chk("rst_latches", {mem_addr, mem_wdata}, 0);
    chk("rst_flags", {ready, mem_re, mem_we}, 0);
    bus_in = 16'h0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; mem_ack = 0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_outputs", {mar_out, mdr_out, mem_addr, mem_wdata}, 0);
    chk("post_rst_flags", {ready, mem_re, mem_we}, 0);
    exp_mar = 16'h0; exp_mdr = 16'h0;

    // Zero-wait read
    mem[16'h3000] = 16'hBEEF;
    load_mar(16'h3000);
    access(1'b0, 0, 1'b0, 0);
    chk("zw_read_mdr", mdr_out, 16'hBEEF);

    // Wait-state write
    load_mdr(16'h1234);
    load_mar(16'hFE06);
    access(1'b1, 3, 1'b0, 0);
    chk("ws_write_mdr", mdr_out, 16'h1234);
    chk("ws_write_wdata", mem_wdata, 16'h1234);

    // Read back written location, with a mid-access MAR load
    load_mar(16'hFE06);
    access(1'b0, 2, 1'b1, 0);
    chk("mid_mar_out", mar_out, 16'h0042);
    chk("readback", mdr_out, 16'h1234);

    // Held request in DONE
    load_mar(16'h3000);
    access(1'b0, 1, 1'b0, 3);
    chk("held_mdr", mdr_out, 16'hBEEF);

    // Random accesses against the memory model
    for (int i = 0; i < 12; i++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 16'hFE06 : 16'($urandom_range(0, 7) * 16'h0101);
      load_mar(ra);
      load_mdr(16'($urandom));
      access(1'($urandom), int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset mid-REQ, then a stray ack
    load_mar(16'h0777);
    r_w = 1'b0; mio_en = 1'b1; mem_ack = 1'b0;
    tick();
    chk("pre_rst_re", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", {mem_re, mem_we}, 0);
    chk("async_rst_ready", ready, 0);
    mio_en = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_flags", {ready, mem_re, mem_we}, 0);
    chk("stray_ack_regs", {mar_out, mdr_out, mem_addr}, 0);
    tick();
    chk("stray_ack_idle", ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_mem_if.md
# lc3_mem_if

Memory interface stage of the LC-3 datapath. It holds MAR and MDR and runs the memory read/write handshake. Its `mdr_out` is the source that the gateMDR tristate buffer drives onto the shared 16-bit bus, so this block sits directly upstream of that buffer. The control FSM drives `ld_mar`, `ld_mdr`, `mio_en` and `r_w`, and holds `mio_en` until `ready` (LC-3 "R") is seen.

## Interface
- `WORD_W`, 16, width of bus, address and data words
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `bus_in`  in  WORD_W  current value of the shared bus
- `ld_mar`  in  1  load MAR from `bus_in`
- `ld_mdr`  in  1  load MDR (source chosen by `mio_en`)
- `mio_en`  in  1  memory access request; held by control until `ready`
- `r_w`  in  1  1 = write, 0 = read; sampled with `mio_en` in IDLE
- `mar_out`  out  WORD_W  MAR contents
- `mdr_out`  out  WORD_W  MDR contents, to gateMDR tristate
- `ready`  out  1  access complete (registered)
- `mem_addr`  out  WORD_W  latched request address
- `mem_wdata`  out  WORD_W  latched write data
- `mem_re`  out  1  read strobe, high throughout REQ for a read
- `mem_we`  out  1  write strobe, high throughout REQ for a write
- `mem_rdata`  in  WORD_W  read data, valid when `mem_ack`=1
- `mem_ack`  in  1  memory completion; may arrive 0..N cycles into REQ

## Operation
- FSM states IDLE, REQ, DONE (`mem_state_e`).
- IDLE:
  - `mio_en`=1 → REQ.
  - On that edge, latch `mem_addr`←MAR, `mem_wdata`←MDR, and direction←`r_w`.
- REQ:
  - Drive `mem_re` or `mem_we` (never both).
  - `mem_ack`=1 → DONE. On a read, capture `mem_rdata` into the read buffer on the same edge.
  - No timeout; REQ waits indefinitely.
- DONE:
  - `ready`=1, strobes low.
  - `mio_en`=0 → IDLE. `mio_en` still 1 → stay in DONE with `ready` held; no new access is issued.
- `mem_ack` is ignored in IDLE and DONE.
- MAR: `ld_mar`=1 loads `bus_in` in any state. `mem_addr` is not affected mid-access.
- MDR:
  - `ld_mdr`=1 with `mio_en`=0 loads `bus_in`.
  - `ld_mdr`=1 with `mio_en`=1 loads the read buffer only in DONE (read access); otherwise MDR holds.
  - `ld_mdr` in DONE after a write leaves MDR unchanged.
- Simultaneous `ld_mar` and the IDLE→REQ transition: `mem_addr` takes the old MAR.
- Simultaneous `ld_mdr` (bus source) and the IDLE→REQ transition is impossible, because `mio_en`=1 selects the memory source.
- Reset:
  - All outputs and registers go to 0; FSM goes to IDLE.
  - Reset asserted mid-REQ drops the strobes immediately (asynchronously); the access is abandoned.
  - Any `mem_ack` arriving after reset release is ignored.

## Timing
- Zero-wait memory (`mem_ack` high in the first REQ cycle):
  - `mio_en` rises before edge 0.
  - REQ occupies cycle 0→1.
  - DONE and `ready`=1 follow edge 1.
  - Latency: 2 edges from `mio_en` to `ready`.
- Each REQ cycle without `mem_ack` adds one cycle.
- `ready`, `mem_re`, `mem_we` are decoded from registered state only; no combinational path from any input.
- `mar_out` and `mdr_out` update on the load edge and are visible the same cycle after the edge.
- Minimum spacing between accesses: DONE→IDLE→REQ, so 1 idle cycle.

## Structure
- `lc3_pkg` holds:
  - `word_t` (logic [15:0]).
  - `mem_state_e` enum.
  - Reset constant `WORD_ZERO`.
- Single module; no sub-module. The MAR, MDR, read buffer and address/data latches are plain registers in this block.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → every output reads 0 and FSM is in IDLE; release → outputs remain 0.
- **Zero-wait read:**
  - Stimulus: `bus_in`=16'h3000 with `ld_mar`. Then `mio_en`=1, `r_w`=0, memory acks immediately with 16'hBEEF.
  - Required: `mem_re` high for exactly 1 cycle with `mem_addr`=16'h3000; `ready` high 2 edges after `mio_en`; `ld_mdr` in DONE → `mdr_out`=16'hBEEF.
- **Wait-state write:**
  - Stimulus: MDR loaded with 16'h1234 from the bus; MAR=16'hFE06; ack after 3 cycles.
  - Required: `mem_we` high for 4 cycles; `mem_wdata`=16'h1234; `mdr_out` unchanged after `ld_mdr` in DONE.
- **Mid-access MAR load:** `ld_mar` with 16'h0042 during REQ → `mar_out`=16'h0042 while `mem_addr` stays at the original address until DONE.
- **Held request:** keep `mio_en`=1 for 3 cycles after `ready` → stays in DONE, `ready` stays 1, no strobe re-asserts; drop `mio_en` → IDLE next edge.
- **Reset mid-REQ and stray ack:**
  - Stimulus: assert `rst_n`=0 during REQ; after release, pulse `mem_ack`.
  - Required: strobes fall immediately on reset; the later `mem_ack` causes no state change.
